// File: rtl/md5_crack_pkg.sv
// md5_crack_pkg: opcodes, state encoding and status layout shared by md5_lane_cracker.
package md5_crack_pkg;
  localparam logic [31:0] OP_NOOP     = 32'h0000_0000;
  localparam logic [31:0] OP_CLEAR    = 32'h5230_0000;
  localparam logic [31:0] OP_START    = 32'h5230_0001;
  localparam logic [31:0] OP_SETEXP   = 32'h5230_1000;
  localparam logic [31:0] OP_SETMASK  = 32'h5230_1004;
  localparam logic [31:0] OP_SETSTART = 32'h5230_2000;
  localparam logic [31:0] OP_SETEND   = 32'h5230_2001;
  localparam logic [31:0] OP_CNT_LO   = 32'h5230_3000;
  localparam logic [31:0] OP_CNT_HI   = 32'h5230_3001;
  localparam logic [31:0] OP_STATUS   = 32'h5230_4000;
  localparam logic [31:0] OP_MATCH_LO = 32'h5230_4001;
  localparam logic [31:0] OP_MATCH_HI = 32'h5230_4002;
  localparam logic [31:0] RSP_OK      = 32'h0000_0000;
  localparam logic [31:0] RSP_ERR     = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RUN = 3'd1, S_DRAIN = 3'd2, S_FOUND = 3'd3, S_EXHAUSTED = 3'd4
  } state_t;
  typedef enum logic [1:0] {A_EXP, A_MASK, A_START, A_END} arg_t;
  function automatic logic [31:0] status_word(input logic [3:0] lanes_m1, input state_t s);
    return {24'b0, lanes_m1, 1'b0, s};
  endfunction
endpackage

// File: rtl/md5_lane_delay.sv
// md5_lane_delay: DEPTH-entry shift register pairing each issued lane mask with its base index.
module md5_lane_delay #(
  parameter int LANES = 4,
  parameter int DEPTH = 64,
  parameter int IDX_W = 48
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             flush,
  input  logic [LANES-1:0] in_mask,
  input  logic [IDX_W-1:0] in_base,
  output logic [LANES-1:0] out_mask,
  output logic [IDX_W-1:0] out_base,
  output logic             busy
);
  logic [LANES-1:0] msk [DEPTH];
  logic [IDX_W-1:0] bas [DEPTH];
  assign out_mask = msk[DEPTH-1];
  assign out_base = bas[DEPTH-1];
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | (|msk[i]);
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        msk[i] <= '0;
        bas[i] <= '0;
      end
    end else begin
      msk[0] <= flush ? '0 : in_mask;
      bas[0] <= in_base;
      for (int i = 1; i < DEPTH; i++) begin
        msk[i] <= flush ? '0 : msk[i-1];
        bas[i] <= bas[i-1];
      end
    end
  end
endmodule

// File: rtl/md5_lane_cracker.sv
// md5_lane_cracker: command-driven index search feeding LANES external MD5 cores.
// Defining MD5_LANE_CRACKER_MASK_EN adds per-word digest compare masks (SetMask A..D).
module md5_lane_cracker
  import md5_crack_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int PIPE_DEPTH = 64,
  parameter int IDX_W      = 48
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   cmdValid,
  output logic                   cmdReady,
  input  logic [31:0]            cmdData,
  output logic                   rspValid,
  output logic [31:0]            rspData,
  output logic                   laneIssue,
  output logic [LANES*IDX_W-1:0] laneIndex,
  input  logic [LANES*128-1:0]   laneDigest,
  output logic                   running,
  output logic                   matched
);
  state_t state, nxt;
  arg_t arg_tgt, tgt;
  logic [1:0] arg_left, arg_sel, n_args;
  logic [31:0] arg_lo, rsp;
  logic [31:0] exp_w [4];
  logic [127:0] exp_all, cmp_mask;
  logic [IDX_W-1:0] start_idx, end_idx, base, match_idx, span, dbase;
  logic [63:0] count, midx;
  logic [LANES-1:0] vmask, dmask, hits, keep, issue_mask;
  logic [3:0] win;
  logic [6:0] inc;
  logic acc, payload, setable, live, last, busy, found, do_clear, do_start, is_exp, is_mask;
`ifdef MD5_LANE_CRACKER_MASK_EN
  logic [31:0] mask_w [4];
  assign cmp_mask = {mask_w[0], mask_w[1], mask_w[2], mask_w[3]};
  assign is_mask = cmdData[31:2] == OP_SETMASK[31:2];
`else
  assign cmp_mask = '1;
  assign is_mask = 1'b0;
`endif
  assign cmdReady = resetN;
  assign acc = cmdValid & cmdReady;
  assign payload = acc && arg_left != 2'd0;
  assign setable = state inside {S_IDLE, S_FOUND, S_EXHAUSTED};
  assign live = state == S_RUN || state == S_DRAIN;
  assign is_exp = cmdData[31:2] == OP_SETEXP[31:2];
  assign exp_all = {exp_w[0], exp_w[1], exp_w[2], exp_w[3]};
  assign midx = 64'(match_idx);
  // base never passes end while running, so end-base cannot wrap
  assign span = end_idx - base;
  assign last = span <= IDX_W'(LANES - 1);
  assign issue_mask = laneIssue ? vmask : '0;
  md5_lane_delay #(.LANES(LANES), .DEPTH(PIPE_DEPTH), .IDX_W(IDX_W)) u_delay (
    .clk(clk), .resetN(resetN), .flush(do_clear || found),
    .in_mask(issue_mask), .in_base(base),
    .out_mask(dmask), .out_base(dbase), .busy(busy)
  );
  always_comb begin
    rsp = RSP_ERR;
    do_clear = 1'b0;
    do_start = 1'b0;
    n_args = 2'd0;
    tgt = A_EXP;
    if (payload) rsp = RSP_OK;
    else if (cmdData == OP_NOOP) rsp = RSP_OK;
    else if (cmdData == OP_CLEAR) begin
      rsp = RSP_OK;
      do_clear = acc;
    end else if (cmdData == OP_START) begin
      if (state == S_IDLE) begin
        rsp = RSP_OK;
        do_start = acc;
      end
    end else if (is_exp || is_mask || cmdData == OP_SETSTART || cmdData == OP_SETEND) begin
      if (setable) begin
        rsp = RSP_OK;
        n_args = (is_exp || is_mask) ? 2'd1 : 2'd2;
        tgt = is_exp ? A_EXP : is_mask ? A_MASK : cmdData[0] ? A_END : A_START;
      end
    end else if (cmdData == OP_CNT_LO) rsp = count[31:0];
    else if (cmdData == OP_CNT_HI) rsp = count[63:32];
    else if (cmdData == OP_STATUS) rsp = status_word(4'(LANES - 1), state);
    else if (cmdData == OP_MATCH_LO) rsp = midx[31:0];
    else if (cmdData == OP_MATCH_HI) rsp = midx[63:32];
  end
  always_comb begin
    vmask = '0;
    hits = '0;
    keep = '0;
    win = '0;
    inc = '0;
    found = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      vmask[k] = span >= IDX_W'(k);
      hits[k] = live && dmask[k] && ((laneDigest[128*k +: 128] ^ exp_all) & cmp_mask) == '0;
    end
    for (int k = LANES - 1; k >= 0; k--) if (hits[k]) win = 4'(k);
    found = |hits;
    // on a hit only lanes up to and including the winner count as searched
    for (int k = 0; k < LANES; k++) begin
      keep[k] = dmask[k] && (!found || 4'(k) <= win);
      inc = inc + 7'(keep[k]);
    end
  end
  always_comb begin
    nxt = state;
    if (do_clear) nxt = S_IDLE;
    else if (do_start) nxt = start_idx <= end_idx ? S_RUN : S_EXHAUSTED;
    else if (found) nxt = S_FOUND;
    else if (state == S_RUN && last) nxt = S_DRAIN;
    else if (state == S_DRAIN && !busy) nxt = S_EXHAUSTED;
  end
  always_comb begin
    for (int k = 0; k < LANES; k++)
      laneIndex[k*IDX_W +: IDX_W] = laneIssue ? base + IDX_W'(k) : '0;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
      running <= 1'b0;
      matched <= 1'b0;
      laneIssue <= 1'b0;
      rspValid <= 1'b0;
      rspData <= '0;
      base <= '0;
      count <= '0;
      match_idx <= '0;
      start_idx <= '0;
      end_idx <= '0;
      arg_left <= '0;
      arg_sel <= '0;
      arg_tgt <= A_EXP;
      arg_lo <= '0;
      for (int i = 0; i < 4; i++) exp_w[i] <= '0;
`ifdef MD5_LANE_CRACKER_MASK_EN
      for (int i = 0; i < 4; i++) mask_w[i] <= '1;
`endif
    end else begin
      state <= nxt;
      running <= nxt == S_RUN || nxt == S_DRAIN;
      matched <= nxt == S_FOUND;
      laneIssue <= nxt == S_RUN;
      rspValid <= acc;
      if (acc) rspData <= rsp;
      if (do_start) base <= start_idx;
      else if (laneIssue) base <= base + IDX_W'(LANES);
      if (do_clear) begin
        count <= '0;
        match_idx <= '0;
      end else if (live) begin
        count <= count + 64'(inc);
        if (found) match_idx <= dbase + IDX_W'(win);
      end
      if (payload) begin
        arg_left <= arg_left - 2'd1;
        arg_lo <= cmdData;
        if (arg_tgt == A_EXP) exp_w[arg_sel] <= cmdData;
`ifdef MD5_LANE_CRACKER_MASK_EN
        if (arg_tgt == A_MASK) mask_w[arg_sel] <= cmdData;
`endif
        if (arg_left == 2'd1 && arg_tgt == A_START) start_idx <= IDX_W'({cmdData, arg_lo});
        if (arg_left == 2'd1 && arg_tgt == A_END) end_idx <= IDX_W'({cmdData, arg_lo});
      end else if (acc) begin
        arg_left <= n_args;
        arg_tgt <= tgt;
        arg_sel <= cmdData[1:0];
      end
    end
  end
endmodule
